// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: size codes, FSM states, window default.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE      = 2'd0;
   localparam logic [1:0] SZ_HALF      = 2'd1;
   localparam logic [1:0] SZ_UNALIGNED = 2'd2;
   localparam logic [1:0] SZ_WORD      = 2'd3;

   localparam logic [15:0] MEM_ADDR_DEFAULT = 16'h1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACCESS2,
      ST_BYTE_WR,
      ST_DONE
   } state_t;

   // Number of bytes touched by a size code (illegal code reported as 4; it is rejected anyway).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extraction: picks n bytes starting at the byte offset out of
// the two captured words and sign/zero-extends them to 32 bits.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   // Shift the 64-bit window right by the byte offset, then extend the low n bytes.
   always_comb begin
      shifted = 32'({word1, word0} >> {off, 3'b000});
      rdata   = 32'd0;
      case (size)
         SZ_BYTE: rdata = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         SZ_WORD: rdata = shifted;
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store unit: one request at a time, lane handling for stores,
// split word reads for word-crossing loads and byte-serial misaligned stores.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [15:0] MEM_ADDR = MEM_ADDR_DEFAULT
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        signed_q, signed_d;
   logic        err_q, err_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] word1_q, word1_d;

   logic [2:0]  req_n;
   logic [15:0] req_end_hi;
   logic        req_err;
   logic        req_aligned;
   logic [2:0]  n_q;
   logic        cross_q;
   logic [1:0]  last_idx;
   logic        we_raw;
   logic [31:0] load_data;

   // Request decode: window check on first and last byte, alignment, latched-request geometry.
   always_comb begin
      req_n       = size_bytes(req_size);
      req_end_hi  = 16'((req_addr + {29'd0, req_n} - 32'd1) >> 16);
      req_err     = (req_size == SZ_UNALIGNED) || (req_addr[31:16] != MEM_ADDR) ||
                    (req_end_hi != MEM_ADDR);
      req_aligned = (req_size == SZ_BYTE) ||
                    ((req_size == SZ_HALF) && !req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] == 2'b00));
      n_q         = size_bytes(size_q);
      cross_q     = ({2'b00, addr_q[1:0]} + {1'b0, n_q}) > 4'd4;
      last_idx    = 2'(n_q - 3'd1);
   end

   // Next-state and request/read-data capture.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      signed_d = signed_q;
      err_d    = err_q;
      size_d   = size_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      word0_d  = word0_q;
      word1_d  = word1_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               signed_d = req_signed;
               size_d   = req_size;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = req_err;
               idx_d    = 2'd0;
               if (req_err)                    state_d = ST_DONE;
               else if (!req_we || req_aligned) state_d = ST_ACCESS;
               else                             state_d = ST_BYTE_WR;
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               word0_d = mem_rdata;
               state_d = cross_q ? ST_ACCESS2 : ST_DONE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_ACCESS2: begin
            word1_d = mem_rdata;
            state_d = ST_DONE;
         end
         ST_BYTE_WR: begin
            idx_d = idx_q + 2'd1;
            if (idx_q == last_idx) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and request registers; low reset clears everything.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'd0;
         idx_q    <= 2'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         word0_q  <= 32'd0;
         word1_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         signed_q <= signed_d;
         err_q    <= err_d;
         size_q   <= size_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         word0_q  <= word0_d;
         word1_q  <= word1_d;
      end
   end

   load_align u_load_align (
      .word0     (word0_q),
      .word1     (word1_q),
      .off       (addr_q[1:0]),
      .size      (size_q),
      .is_signed (signed_q),
      .rdata     (load_data)
   );

   // Moore outputs decoded from the current state and latched request.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      mem_size   = SZ_BYTE;
      mem_re     = 1'b0;
      we_raw     = 1'b0;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_ACCESS: begin
            if (we_q) begin
               mem_addr  = addr_q;
               mem_size  = size_q;
               mem_wdata = wdata_q;
               we_raw    = 1'b1;
            end else begin
               mem_addr = {addr_q[31:2], 2'b00};
               mem_re   = 1'b1;
            end
         end
         ST_ACCESS2: begin
            mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
            mem_re   = 1'b1;
         end
         ST_BYTE_WR: begin
            mem_addr  = addr_q + {30'd0, idx_q};
            mem_size  = SZ_BYTE;
            mem_wdata = {24'd0, 8'(wdata_q >> {idx_q, 3'b000})};
            we_raw    = 1'b1;
         end
         ST_DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (!err_q && !we_q) ? load_data : 32'd0;
         end
         default: ;
      endcase
   end

   // A write must never land on the edge that applies reset.
   assign mem_we = we_raw & reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: byte-laned memory model on the pins, plus a byte-array
// reference of what memory should hold and what each request should return.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata = 32'd0;

   int tests = 0;
   int fails = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int both_cnt = 0;

   logic [7:0]  phys  [0:65535];
   logic [7:0]  model [0:65535];
   logic        pend_we = 1'b0;
   logic [31:0] pend_addr = 32'd0;
   logic [31:0] pend_data = 32'd0;
   logic [1:0]  pend_size = 2'd0;

   always #5 clock = ~clock;

   mem_access_unit #(.MEM_ADDR(16'h1000)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   // Memory pins: reads on the falling edge, writes committed on the rising edge.
   always @(negedge clock) begin
      logic [15:0] a;
      a = {mem_addr[15:2], 2'b00};
      if (mem_re)
         mem_rdata = (mem_addr[31:16] == 16'h1000) ?
                     {phys[a + 16'd3], phys[a + 16'd2], phys[a + 16'd1], phys[a]} : 32'hBAD0BAD0;
      pend_we   = mem_we;
      pend_addr = mem_addr;
      pend_data = mem_wdata;
      pend_size = mem_size;
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (mem_we && mem_re) both_cnt++;
   end

   always @(posedge clock) begin
      logic [31:0] ak;
      if (pend_we) begin
         for (int k = 0; k < nbytes(pend_size); k++) begin
            ak = pend_addr + 32'(k);
            if (ak[31:16] == 16'h1000) phys[ak[15:0]] = pend_data[8*k +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete request with expectations derived from the byte-array reference.
   task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
      int n, cyc, exp_lat, exp_we, exp_re;
      logic exp_err, aligned, crossing, done;
      logic [31:0] exp_data, ak, endaddr;
      n        = nbytes(sz);
      endaddr  = addr + 32'(n) - 32'd1;
      exp_err  = (sz == 2'd2) || (addr[31:16] != 16'h1000) || (endaddr[31:16] != 16'h1000);
      aligned  = (int'(addr[1:0]) % n) == 0;
      crossing = int'(addr[1:0]) + n > 4;
      exp_data = 32'd0;
      if (!exp_err && !we) begin
         for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            exp_data = exp_data | (32'(model[ak[15:0]]) << (8 * k));
         end
         if (sg && n == 1) exp_data = {{24{exp_data[7]}}, exp_data[7:0]};
         if (sg && n == 2) exp_data = {{16{exp_data[15]}}, exp_data[15:0]};
      end
      exp_lat = exp_err ? 2 : (!we ? (crossing ? 4 : 3) : (aligned ? 3 : 2 + n));
      exp_we  = (exp_err || !we) ? 0 : (aligned ? 1 : n);
      exp_re  = (exp_err || we) ? 0 : (crossing ? 2 : 1);

      @(posedge clock); #1;
      we_cnt = 0; re_cnt = 0; both_cnt = 0;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      @(negedge clock);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      cyc = 1; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clock);
         cyc++;
         if (resp_valid) done = 1'b1;
      end
      got = resp_rdata;
      chk("resp_seen", {31'd0, done}, 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      chk("resp_rdata", resp_rdata, exp_data);
      @(negedge clock);
      chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      chk("ready_after", {31'd0, req_ready}, 32'd1);
      chk("we_cycles", 32'(we_cnt), 32'(exp_we));
      chk("re_cycles", 32'(re_cnt), 32'(exp_re));
      chk("we_re_both", 32'(both_cnt), 32'd0);
      if (we && !exp_err) begin
         for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            model[ak[15:0]] = wd[8*k +: 8];
            chk("store_byte", {24'd0, phys[ak[15:0]]}, {24'd0, model[ak[15:0]]});
         end
      end
      $display("[TB] txn we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               we, sz, sg, addr, wd, got, resp_err, cyc);
   endtask

   initial begin
      logic [31:0] got, a;
      logic [1:0]  sz;
      int mism, sel;
      for (int i = 0; i < 65536; i++) begin
         phys[i]  = 8'($urandom);
         model[i] = phys[i];
      end
      {phys[16'h13], phys[16'h12], phys[16'h11], phys[16'h10]}     = 32'hDEADBEEF;
      {model[16'h13], model[16'h12], model[16'h11], model[16'h10]} = 32'hDEADBEEF;

      // Reset state.
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_mem_ctl", {30'd0, mem_we, mem_re}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_size", {30'd0, mem_size}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;

      // Directed cases.
      txn(1'b0, SZ_WORD, 1'b0, 32'h10000010, 32'd0, got); chk("lw_plan", got, 32'hDEADBEEF);
      txn(1'b0, SZ_BYTE, 1'b1, 32'h10000013, 32'd0, got); chk("lb_plan", got, 32'hFFFFFFDE);
      txn(1'b0, SZ_BYTE, 1'b0, 32'h10000013, 32'd0, got); chk("lbu_plan", got, 32'h000000DE);
      txn(1'b0, SZ_HALF, 1'b0, 32'h10000012, 32'd0, got); chk("lhu_plan", got, 32'h0000DEAD);
      txn(1'b1, SZ_WORD, 1'b0, 32'h10000021, 32'h11223344, got);
      chk("sw_bytes", {phys[16'h24], phys[16'h23], phys[16'h22], phys[16'h21]}, 32'h11223344);
      txn(1'b0, SZ_WORD, 1'b0, 32'h10000021, 32'd0, got); chk("lw_cross_plan", got, 32'h11223344);
      txn(1'b1, SZ_WORD, 1'b0, 32'h20000000, 32'h55555555, got); chk("sw_oob_rdata", got, 32'd0);
      txn(1'b0, SZ_UNALIGNED, 1'b0, 32'h10000040, 32'd0, got);
      txn(1'b0, SZ_WORD, 1'b0, 32'h1000FFFE, 32'd0, got);
      txn(1'b1, SZ_HALF, 1'b0, 32'hFFFFFFFF, 32'h0000ABCD, got);
      txn(1'b1, SZ_HALF, 1'b0, 32'h10000043, 32'h0000ABCD, got);

      // Reset during the second byte write of a misaligned store.
      @(posedge clock); #1;
      we_cnt = 0;
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
      req_addr = 32'h10000031; req_wdata = 32'h11223344;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mid_we_gated", {31'd0, mem_we}, 32'd0);
      chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mid_no_resp2", {31'd0, resp_valid}, 32'd0);
      chk("rst_mid_we_cnt", 32'(we_cnt), 32'd1);
      model[16'h31] = 8'h44;
      chk("rst_mid_bytes", {phys[16'h34], phys[16'h33], phys[16'h32], phys[16'h31]},
          {model[16'h34], model[16'h33], model[16'h32], model[16'h31]});
      $display("[TB] txn reset during byte write at 10000031 done");

      // Randomized requests.
      for (int t = 0; t < 150; t++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       a = $urandom;
            1:       a = 32'h1000FFFC + $urandom_range(0, 3);
            2:       a = 32'h0FFFFFFD + $urandom_range(0, 2);
            default: a = 32'h10000000 + $urandom_range(0, 127);
         endcase
         sz = 2'($urandom_range(0, 3));
         txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
      end

      mism = 0;
      for (int i = 0; i < 65536; i++) if (phys[i] !== model[i]) mism++;
      chk("mem_image", 32'(mism), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
